updi_responder: RTL

Target-side UPDI responder: the device end of the link driven by the UPDI programmer interface. It parses SYNCH/opcode/operand bytes from the UART RX FIFO, executes LDCS, STCS, LDS and STS against an internal control/status (CS) register array and an external byte-wide memory bus, and returns data and ACK bytes through the UART TX FIFO. The block serves as an on-FPGA target model for loopback verification of the programmer path. Echo suppression on the half-duplex line is handled upstream in the UART layer.

---
 rtl/updi_pkg.sv | 39 +++
 rtl/updi_cs_regfile.sv | 28 ++
 rtl/updi_responder.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/updi_pkg.sv
// Shared UPDI constants, responder state encoding and opcode support check.
package updi_pkg;

    localparam logic [7:0] Synch = 8'h55;
    localparam logic [7:0] Ack   = 8'h40;

    localparam logic [2:0] OpLds    = 3'b000;
    localparam logic [2:0] OpLd     = 3'b001;
    localparam logic [2:0] OpSts    = 3'b010;
    localparam logic [2:0] OpSt     = 3'b011;
    localparam logic [2:0] OpLdcs   = 3'b100;
    localparam logic [2:0] OpRepeat = 3'b101;
    localparam logic [2:0] OpStcs   = 3'b110;
    localparam logic [2:0] OpKey    = 3'b111;

    typedef enum logic [3:0] {
        StIdle,
        StOpcode,
        StAddrLo,
        StAddrHi,
        StMemRd,
        StMemWait,
        StMemWr,
        StDataIn,
        StTxData,
        StTxAck
    } updi_resp_state_t;

    // Only byte/word addressing with byte data, and CS accesses with op[4] clear.
    function automatic logic op_supported(input logic [7:0] op);
        case (op[7:5])
            OpLds, OpSts:                 return (op[3] == 1'b0) && (op[1:0] == 2'b00);
            OpLdcs, OpStcs:               return op[4] == 1'b0;
            OpLd, OpSt, OpRepeat, OpKey:  return 1'b0;
            default:                      return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/updi_cs_regfile.sv
// 16x8 control/status register array: one write port, one combinational read port.
module updi_cs_regfile #(
    parameter logic [7:0] STATUSA_RESET = 8'h30
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       we,
    input  logic [3:0] waddr,
    input  logic [7:0] wdata,
    input  logic [3:0] raddr,
    output logic [7:0] rdata
);

    logic [7:0] regs_q [16];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 16; i++) begin
                regs_q[i] <= (i == 0) ? STATUSA_RESET : 8'h00;
            end
        end else if (we) begin
            regs_q[waddr] <= wdata;
        end
    end

    assign rdata = regs_q[raddr];

endmodule

// File: rtl/updi_responder.sv
// Target-side UPDI responder: parses RX FIFO frames, runs LDCS/STCS/LDS/STS
// against the CS array and a byte memory bus, and answers through the TX FIFO.
module updi_responder
    import updi_pkg::*;
#(
    parameter int unsigned TIMEOUT_CLKS  = 100,
    parameter logic [7:0]  STATUSA_RESET = 8'h30
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  uart_rx_fifo_data,
    output logic        uart_rx_fifo_rd_en,
    input  logic        uart_rx_fifo_empty,
    output logic [7:0]  uart_tx_fifo_data,
    output logic        uart_tx_fifo_wr_en,
    input  logic        uart_tx_fifo_full,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_wdata,
    output logic        mem_we,
    output logic        mem_re,
    input  logic [7:0]  mem_rdata,
    output logic        busy,
    output logic        frame_error,
    output logic        unsupported
);

    localparam int unsigned TW = $clog2(TIMEOUT_CLKS + 1);

    updi_resp_state_t state_q;
    logic [TW-1:0]    tmo_q;
    logic [7:0]       data_q;
    logic [3:0]       cs_addr_q;
    logic             is_cs_q;
    logic             is_sts_q;
    logic             wide_q;
    logic             data_done_q;

    logic       pop_state;
    logic       tmo_state;
    logic [7:0] rx;
    logic       cs_we;
    logic [7:0] cs_rdata;

    assign rx        = uart_rx_fifo_data;
    assign pop_state = (state_q == StIdle) || (state_q == StOpcode) || (state_q == StAddrLo) ||
                       (state_q == StAddrHi) || (state_q == StDataIn);
    assign tmo_state = pop_state && (state_q != StIdle);

    assign uart_rx_fifo_rd_en = pop_state && !uart_rx_fifo_empty;
    assign uart_tx_fifo_wr_en = ((state_q == StTxData) || (state_q == StTxAck)) &&
                                !uart_tx_fifo_full;
    assign uart_tx_fifo_data  = (state_q == StTxAck) ? Ack : data_q;
    assign busy               = (state_q != StIdle);

    // CS writes land on the same edge that pops the STCS data byte.
    assign cs_we = (state_q == StDataIn) && is_cs_q && uart_rx_fifo_rd_en;

    updi_cs_regfile #(
        .STATUSA_RESET(STATUSA_RESET)
    ) u_cs_regfile (
        .clk   (clk),
        .rst   (rst),
        .we    (cs_we),
        .waddr (cs_addr_q),
        .wdata (rx),
        .raddr (rx[3:0]),
        .rdata (cs_rdata)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StIdle;
            tmo_q       <= '0;
            data_q      <= 8'h00;
            cs_addr_q   <= 4'h0;
            is_cs_q     <= 1'b0;
            is_sts_q    <= 1'b0;
            wide_q      <= 1'b0;
            data_done_q <= 1'b0;
            mem_addr    <= 16'h0000;
            mem_wdata   <= 8'h00;
            mem_we      <= 1'b0;
            mem_re      <= 1'b0;
            frame_error <= 1'b0;
            unsupported <= 1'b0;
        end else begin
            mem_we      <= 1'b0;
            mem_re      <= 1'b0;
            frame_error <= 1'b0;
            unsupported <= 1'b0;

            // Starvation only ever fires when nothing is popped, so it never races the FSM.
            if (tmo_state && uart_rx_fifo_empty) begin
                if (tmo_q == TW'(TIMEOUT_CLKS - 1)) begin
                    tmo_q       <= '0;
                    frame_error <= 1'b1;
                    state_q     <= StIdle;
                end else begin
                    tmo_q <= tmo_q + 1'b1;
                end
            end else begin
                tmo_q <= '0;
            end

            case (state_q)
                StIdle: begin
                    if (uart_rx_fifo_rd_en && rx == Synch) state_q <= StOpcode;
                end
                StOpcode: begin
                    if (uart_rx_fifo_rd_en) begin
                        if (!op_supported(rx)) begin
                            unsupported <= 1'b1;
                            state_q     <= StIdle;
                        end else if (rx[7:5] == OpLdcs) begin
                            data_q  <= cs_rdata;
                            state_q <= StTxData;
                        end else if (rx[7:5] == OpStcs) begin
                            cs_addr_q <= rx[3:0];
                            is_cs_q   <= 1'b1;
                            state_q   <= StDataIn;
                        end else begin
                            is_cs_q     <= 1'b0;
                            is_sts_q    <= (rx[7:5] == OpSts);
                            wide_q      <= rx[2];
                            data_done_q <= 1'b0;
                            state_q     <= StAddrLo;
                        end
                    end
                end
                StAddrLo: begin
                    if (uart_rx_fifo_rd_en) begin
                        mem_addr <= {8'h00, rx};
                        if (wide_q) begin
                            state_q <= StAddrHi;
                        end else if (is_sts_q) begin
                            state_q <= StTxAck;
                        end else begin
                            mem_re  <= 1'b1;
                            state_q <= StMemRd;
                        end
                    end
                end
                StAddrHi: begin
                    if (uart_rx_fifo_rd_en) begin
                        mem_addr[15:8] <= rx;
                        if (is_sts_q) begin
                            state_q <= StTxAck;
                        end else begin
                            mem_re  <= 1'b1;
                            state_q <= StMemRd;
                        end
                    end
                end
                StMemRd:   state_q <= StMemWait;
                StMemWait: begin
                    data_q  <= mem_rdata;
                    state_q <= StTxData;
                end
                StDataIn: begin
                    if (uart_rx_fifo_rd_en) begin
                        if (is_cs_q) begin
                            state_q <= StIdle;
                        end else begin
                            mem_wdata <= rx;
                            mem_we    <= 1'b1;
                            state_q   <= StMemWr;
                        end
                    end
                end
                StMemWr: begin
                    data_done_q <= 1'b1;
                    state_q     <= StTxAck;
                end
                StTxData: begin
                    if (!uart_tx_fifo_full) state_q <= StIdle;
                end
                StTxAck: begin
                    if (!uart_tx_fifo_full) state_q <= data_done_q ? StIdle : StDataIn;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule
